// File: rtl/writeback_stage_pkg.sv
// Shared widths, reset values, store-buffer FSM encoding and entry layout for the writeback stage.
// Latency: n/a (declarations only); backpressure: n/a.
package writeback_stage_pkg;

  localparam int DATA_W      = 8;
  localparam int REG_CNT     = 8;
  localparam int PORT_CNT    = 8;
  localparam int REG_AW      = $clog2(REG_CNT);
  localparam int PORT_AW     = $clog2(PORT_CNT);
  localparam logic [DATA_W-1:0] SP_RESET = 8'hFF;

  localparam int STBUF_DEPTH = 2;
  localparam int STBUF_CW    = $clog2(STBUF_DEPTH + 1);
  localparam int STBUF_PW    = (STBUF_DEPTH > 1) ? $clog2(STBUF_DEPTH) : 1;

  typedef enum logic [0:0] {
    SB_IDLE = 1'b0,
    SB_REQ  = 1'b1
  } sb_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } st_entry_t;

  function automatic logic [PORT_CNT-1:0] port_onehot(input logic [PORT_AW-1:0] idx);
    logic [PORT_CNT-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/store_buffer.sv
// Small FIFO of pending stores drained one at a time through a mem_req/mem_ack handshake.
// Latency: entry reaches mem_req two edges after wr; backpressure: stall when full, extra writes dropped into sticky ovf.
module store_buffer
  import writeback_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,
  input  st_entry_t         entry_i,
  input  logic              mem_ack_i,
  output logic              mem_req_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              stall_o,
  output logic              ovf_o
);

  localparam logic [STBUF_CW-1:0] FULL_CNT = STBUF_CW'(STBUF_DEPTH);
  localparam logic [STBUF_PW-1:0] LAST_PTR = STBUF_PW'(STBUF_DEPTH - 1);

  function automatic logic [STBUF_PW-1:0] ptr_inc(input logic [STBUF_PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  st_entry_t           entries_q [STBUF_DEPTH];
  logic [STBUF_PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [STBUF_PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [STBUF_CW-1:0] count_q, count_d;
  sb_state_e           state_q, state_d;
  logic                ovf_q, ovf_d;
  logic                full, pop, push, drop;

  // A write into a full buffer still fits when the head retires on the same edge.
  assign full = (count_q == FULL_CNT);
  assign pop  = (state_q == SB_REQ) && mem_ack_i;
  assign push = wr_i && (!full || pop);
  assign drop = wr_i && full && !pop;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q | drop;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_IDLE: if (count_q != '0) state_d = SB_REQ;
      SB_REQ:  if (pop && (count_d == '0)) state_d = SB_IDLE;
      default: state_d = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SB_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < STBUF_DEPTH; i++) entries_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ovf_q    <= ovf_d;
      if (push) entries_q[wr_ptr_q] <= entry_i;
    end
  end

  assign mem_req_o  = (state_q == SB_REQ);
  assign mem_addr_o = entries_q[rd_ptr_q].addr;
  assign mem_data_o = entries_q[rd_ptr_q].data;
  assign stall_o    = full;
  assign ovf_o      = ovf_q;

endmodule

// File: rtl/writeback_stage.sv
// Stage-4 writeback: register file with write bypass, stack pointer, output ports, buffered stores.
// Latency: state updates at next edge, reads bypass same-cycle writes; backpressure: stall while store buffer is full.
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lrn,
  input  logic                       lr0,
  input  logic                       lsp,
  input  logic                       dsp,
  input  logic                       isp,
  input  logic                       lop,
  input  logic                       wr,
  input  logic [REG_AW-1:0]          rn_sel,
  input  logic [PORT_AW-1:0]         pn_sel,
  input  logic [DATA_W-1:0]          data_in,
  input  logic [DATA_W-1:0]          alu_in,
  input  logic [DATA_W-1:0]          mem_addr_in,
  input  logic [REG_AW-1:0]          rd_a_sel,
  input  logic [REG_AW-1:0]          rd_b_sel,
  output logic [DATA_W-1:0]          rd_a,
  output logic [DATA_W-1:0]          rd_b,
  output logic [DATA_W-1:0]          sp_out,
  output logic [PORT_CNT*DATA_W-1:0] port_data,
  output logic [PORT_CNT-1:0]        port_strobe,
  output logic                       mem_req,
  output logic [DATA_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data,
  input  logic                       mem_ack,
  output logic                       stall,
  output logic                       ovf
);

  logic [DATA_W-1:0]   regs_q [REG_CNT];
  logic [DATA_W-1:0]   regs_d [REG_CNT];
  logic [DATA_W-1:0]   sp_q, sp_d;
  logic [DATA_W-1:0]   port_q [PORT_CNT];
  logic [DATA_W-1:0]   port_d [PORT_CNT];
  logic [PORT_CNT-1:0] port_strobe_q, port_strobe_d;
  st_entry_t           st_entry;

  // lr0 is applied after lrn so it wins when both target R0.
  always_comb begin
    for (int i = 0; i < REG_CNT; i++) regs_d[i] = regs_q[i];
    if (!rst) begin
      if (lrn) regs_d[rn_sel] = data_in;
      if (lr0) regs_d[0]      = alu_in;
    end
  end

  // Reading the next-state array gives zero-cycle write-to-read forwarding.
  assign rd_a = regs_d[rd_a_sel];
  assign rd_b = regs_d[rd_b_sel];

  always_comb begin
    sp_d = sp_q;
    if (lsp)               sp_d = data_in;
    else if (dsp && !isp)  sp_d = sp_q - 1'b1;
    else if (isp && !dsp)  sp_d = sp_q + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < PORT_CNT; i++) port_d[i] = port_q[i];
    port_strobe_d = '0;
    if (lop) begin
      port_d[pn_sel] = alu_in;
      port_strobe_d  = port_onehot(pn_sel);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++)  regs_q[i] <= '0;
      for (int i = 0; i < PORT_CNT; i++) port_q[i] <= '0;
      sp_q          <= SP_RESET;
      port_strobe_q <= '0;
    end else begin
      for (int i = 0; i < REG_CNT; i++)  regs_q[i] <= regs_d[i];
      for (int i = 0; i < PORT_CNT; i++) port_q[i] <= port_d[i];
      sp_q          <= sp_d;
      port_strobe_q <= port_strobe_d;
    end
  end

  for (genvar g = 0; g < PORT_CNT; g++) begin : g_port
    assign port_data[g*DATA_W +: DATA_W] = port_q[g];
  end

  assign sp_out      = sp_q;
  assign port_strobe = port_strobe_q;

  assign st_entry.addr = mem_addr_in;
  assign st_entry.data = data_in;

  store_buffer u_store_buffer (
    .clk        (clk),
    .rst        (rst),
    .wr_i       (wr),
    .entry_i    (st_entry),
    .mem_ack_i  (mem_ack),
    .mem_req_o  (mem_req),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_data),
    .stall_o    (stall),
    .ovf_o      (ovf)
  );

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: register file, SP, output ports, store buffer and reset behaviour.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        lrn, lr0, lsp, dsp, isp, lop, wr;
  logic [2:0]  rn_sel, pn_sel, rd_a_sel, rd_b_sel;
  logic [7:0]  data_in, alu_in, mem_addr_in;
  logic [7:0]  rd_a, rd_b, sp_out, mem_addr, mem_data;
  logic [63:0] port_data;
  logic [7:0]  port_strobe;
  logic        mem_req, mem_ack, stall, ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst(rst),
    .lrn(lrn), .lr0(lr0), .lsp(lsp), .dsp(dsp), .isp(isp), .lop(lop), .wr(wr),
    .rn_sel(rn_sel), .pn_sel(pn_sel),
    .data_in(data_in), .alu_in(alu_in), .mem_addr_in(mem_addr_in),
    .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .rd_a(rd_a), .rd_b(rd_b),
    .sp_out(sp_out), .port_data(port_data), .port_strobe(port_strobe),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .stall(stall), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lrn = 0; lr0 = 0; lsp = 0; dsp = 0; isp = 0; lop = 0; wr = 0;
    mem_ack = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1; rn_sel = 0; pn_sel = 0; rd_a_sel = 0; rd_b_sel = 7;
    data_in = 0; alu_in = 0; mem_addr_in = 0;
    tick(); tick();
    rst = 0;
    #1;

    // Reset state
    chk("rst_sp",     sp_out, 64'hFF);
    chk("rst_ports",  port_data, 64'h0);
    chk("rst_strobe", port_strobe, 64'h0);
    chk("rst_memreq", mem_req, 64'h0);
    chk("rst_stall",  stall, 64'h0);
    chk("rst_ovf",    ovf, 64'h0);
    chk("rst_r0",     rd_a, 64'h0);
    chk("rst_r7",     rd_b, 64'h0);

    // Register write with same-cycle bypass, then registered read
    lrn = 1; rn_sel = 3; data_in = 8'h5A; rd_a_sel = 3; rd_b_sel = 2;
    #1;
    chk("bypass_r3",   rd_a, 64'h5A);
    chk("bypass_r2",   rd_b, 64'h00);
    tick();
    idle_inputs(); data_in = 8'h00;
    #1;
    chk("read_r3",     rd_a, 64'h5A);

    // lr0 beats lrn on R0
    lrn = 1; rn_sel = 0; data_in = 8'h11; lr0 = 1; alu_in = 8'h22; rd_a_sel = 0;
    #1;
    chk("bypass_r0_lr0", rd_a, 64'h22);
    tick();
    idle_inputs();
    #1;
    chk("r0_lr0_wins", rd_a, 64'h22);

    // lrn to R4 and lr0 both land
    lrn = 1; rn_sel = 4; data_in = 8'h33; lr0 = 1; alu_in = 8'h44;
    tick();
    idle_inputs(); rd_a_sel = 4; rd_b_sel = 0;
    #1;
    chk("dual_r4", rd_a, 64'h33);
    chk("dual_r0", rd_b, 64'h44);

    // Stack pointer
    dsp = 1; tick(); idle_inputs();
    chk("sp_dec_fe", sp_out, 64'hFE);
    lsp = 1; data_in = 8'hFF; tick(); idle_inputs();
    chk("sp_load_ff", sp_out, 64'hFF);
    isp = 1; tick(); idle_inputs();
    chk("sp_inc_wrap", sp_out, 64'h00);
    dsp = 1; isp = 1; tick(); idle_inputs();
    chk("sp_dec_inc_hold", sp_out, 64'h00);
    dsp = 1; tick(); idle_inputs();
    chk("sp_dec_wrap", sp_out, 64'hFF);
    lsp = 1; dsp = 1; data_in = 8'h80; tick(); idle_inputs();
    chk("sp_load_prio", sp_out, 64'h80);

    // Output port load and one-cycle strobe
    lop = 1; pn_sel = 5; alu_in = 8'hC3;
    tick(); idle_inputs();
    chk("port5_data",   port_data, 64'h0000_C300_0000_0000);
    chk("port5_strobe", port_strobe, 64'h20);
    tick();
    chk("port5_strobe_off", port_strobe, 64'h00);
    chk("port5_hold",       port_data, 64'h0000_C300_0000_0000);

    // Store buffer overflow and in-order drain
    wr = 1; mem_addr_in = 8'h10; data_in = 8'hA0; tick();
    chk("st1_stall", stall, 64'h0);
    chk("st1_req",   mem_req, 64'h0);
    mem_addr_in = 8'h11; data_in = 8'hA1; tick();
    chk("st2_stall", stall, 64'h1);
    chk("st2_req",   mem_req, 64'h1);
    chk("st2_addr",  mem_addr, 64'h10);
    chk("st2_data",  mem_data, 64'hA0);
    chk("st2_ovf",   ovf, 64'h0);
    mem_addr_in = 8'h12; data_in = 8'hA2; tick();
    idle_inputs();
    chk("st3_ovf",   ovf, 64'h1);
    chk("st3_stall", stall, 64'h1);
    chk("st3_addr",  mem_addr, 64'h10);
    tick();
    chk("wait_addr_stable", mem_addr, 64'h10);
    mem_ack = 1; tick();
    chk("ack1_req",   mem_req, 64'h1);
    chk("ack1_addr",  mem_addr, 64'h11);
    chk("ack1_data",  mem_data, 64'hA1);
    chk("ack1_stall", stall, 64'h0);
    tick(); mem_ack = 0;
    chk("ack2_req",   mem_req, 64'h0);
    chk("ack2_ovf",   ovf, 64'h1);
    mem_ack = 1; tick(); mem_ack = 0;
    chk("stray_ack_req",   mem_req, 64'h0);
    chk("stray_ack_stall", stall, 64'h0);

    // Reset during an outstanding request with concurrent ack and strobes
    wr = 1; mem_addr_in = 8'h40; data_in = 8'hB0; tick();
    wr = 0; tick();
    chk("pre_rst_req",  mem_req, 64'h1);
    chk("pre_rst_addr", mem_addr, 64'h40);
    rst = 1; mem_ack = 1; lrn = 1; rn_sel = 3; data_in = 8'hEE; dsp = 1; lop = 1;
    tick();
    rst = 0; idle_inputs(); rd_a_sel = 3;
    #1;
    chk("rst_req_drop",  mem_req, 64'h0);
    chk("rst_req_stall", stall, 64'h0);
    chk("rst_req_ovf",   ovf, 64'h0);
    chk("rst_req_sp",    sp_out, 64'hFF);
    chk("rst_req_r3",    rd_a, 64'h00);
    chk("rst_req_ports", port_data, 64'h0);
    tick();
    chk("rst_req_stays_idle", mem_req, 64'h0);

    // Write into a full buffer accepted when the head pops on the same edge
    wr = 1; mem_addr_in = 8'h20; data_in = 8'hC0; tick();
    mem_addr_in = 8'h21; data_in = 8'hC1; tick();
    chk("fp_full", stall, 64'h1);
    mem_addr_in = 8'h22; data_in = 8'hC2; mem_ack = 1; tick();
    wr = 0;
    chk("fp_addr",  mem_addr, 64'h21);
    chk("fp_stall", stall, 64'h1);
    chk("fp_ovf",   ovf, 64'h0);
    tick();
    chk("fp_addr3", mem_addr, 64'h22);
    chk("fp_data3", mem_data, 64'hC2);
    chk("fp_stall3", stall, 64'h0);
    tick(); mem_ack = 0;
    chk("fp_drained", mem_req, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have ports: clk  in  1  global clock, all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have ports lrn, lr0, lsp, dsp, isp, lop, wr  in  1 each  stage-4 control strobes: load Rn, load R0, load SP, decrement SP, increment SP, load output port, memory write.
REQ-004 SHALL have ports rn_sel  in  3  destination register; pn_sel  in  3  output port index.
REQ-005 SHALL have ports data_in  in  8  operand/load data; alu_in  in  8  ALU result; mem_addr_in  in  8  store address.
REQ-006 SHALL have ports rd_a_sel, rd_b_sel  in  3; rd_a, rd_b  out  8  register read ports.
REQ-007 SHALL have ports sp_out  out  8  current SP; port_data  out  8x8 (64)  output port registers; port_strobe  out  8  one-hot update pulse.
REQ-008 SHALL have ports mem_req  out  1; mem_addr, mem_data  out  8; mem_ack  in  1; stall  out  1; ovf  out  1  sticky store-drop flag.

Function
REQ-009 SHALL hold register file R0..R7, 8 bits each.
REQ-010 lrn SHALL write data_in to R[rn_sel] at next edge; lr0 SHALL write alu_in to R0.
REQ-011 lrn with rn_sel=0 and lr0 together: lr0 SHALL win; lrn with rn_sel!=0 and lr0 together: both writes SHALL occur.
REQ-012 rd_a/rd_b SHALL be combinational reads with same-cycle bypass of any write pending this cycle (zero-cycle write-to-read latency).
REQ-013 SP priority: lsp (SP<=data_in) > dsp/isp; dsp with isp together SHALL leave SP unchanged.
REQ-014 dsp SHALL compute SP-1 mod 256 (0x00->0xFF); isp SHALL compute SP+1 mod 256 (0xFF->0x00).
REQ-015 lop SHALL load alu_in into port_data[pn_sel] and pulse port_strobe[pn_sel] high exactly one cycle after the edge.
REQ-016 wr SHALL push {mem_addr_in, data_in} into a 2-entry FIFO store buffer.
REQ-017 Store FSM states IDLE, REQ: IDLE->REQ when buffer non-empty; REQ holds mem_req=1 with head addr/data stable until mem_ack=1; on ack pop head, go IDLE if empty else stay REQ with new head next cycle.
REQ-018 mem_ack while mem_req=0 SHALL be ignored.
REQ-019 stall SHALL be 1 whenever buffer count==2, combinationally from count.
REQ-020 wr when count==2 and no pop this cycle SHALL drop the entry and set ovf=1 until reset; wr with count==2 and simultaneous pop SHALL be accepted.
REQ-021 Store ordering SHALL be strictly FIFO.

Reset
REQ-022 On rst: R0..R7=0x00, SP=0xFF, port_data=0, port_strobe=0, buffer empty, FSM IDLE, mem_req=0, stall=0, ovf=0.
REQ-023 rst during REQ SHALL drop mem_req at the next edge and discard buffered stores; a concurrent mem_ack SHALL be ignored.
REQ-024 rst SHALL override every strobe asserted in the same cycle.

Structure
REQ-025 Shared package SHALL hold DATA_W=8, REG_CNT=8, PORT_CNT=8, SP_RESET=8'hFF, STBUF_DEPTH=2 and FSM state encoding.
REQ-026 Store buffer plus FSM SHALL be one sub-module store_buffer; register file, SP and ports stay in writeback_stage.

Verification
REQ-027 lrn rn_sel=3 data_in=0x5A, next cycle rd_a_sel=3 -> rd_a=0x5A; same-cycle read -> 0x5A via bypass.
REQ-028 lrn rn_sel=0 data_in=0x11 with lr0 alu_in=0x22 -> R0=0x22.
REQ-029 After reset dsp one cycle -> SP=0xFE; lsp data_in=0xFF then isp -> SP=0x00; dsp+isp together -> SP unchanged.
REQ-030 Three wr (addrs 0x10,0x11,0x12) with mem_ack low -> stall=1 after second, third dropped, ovf=1; ack twice -> mem_addr 0x10 then 0x11, mem_req low after.
REQ-031 mem_req high with addr 0x40, assert rst with mem_ack -> next cycle mem_req=0, stall=0, ovf=0, SP=0xFF.
REQ-032 lop pn_sel=5 alu_in=0xC3 -> port_data[5]=0xC3, port_strobe=8'b0010_0000 for exactly one cycle.
